// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//
// Quadrature encoder front end. Raw A/B pins are synchronised, glitch filtered
// and decoded into single-cycle step pulses with a direction flag, matching the
// enable/up_down form used by the up/down counter. A wrapping position counter
// and a sticky illegal-transition flag are kept locally.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   quad_a   in   1      encoder channel A (asynchronous)
//   quad_b   in   1      encoder channel B (asynchronous)
//   clear    in   1      synchronous clear of count and err
//   count    out  WIDTH  position, wraps modulo 2**WIDTH
//   step     out  1      one-cycle pulse per legal quadrature edge
//   dir      out  1      1 = up, 0 = down; holds last value between steps
//   err      out  1      sticky: both channels changed in the same cycle
// -----------------------------------------------------------------------------
module quad_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err
);

    // Run counter only needs to hold 0..FILTER_LEN-1.
    localparam int RUN_W  = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(FILTER_LEN - 1);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1'b1);
    localparam logic [RUN_W-1:0]  RUN_ZERO  = RUN_W'(1'b0);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1'b1);
    localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0]  CNT_ZERO  = WIDTH'(1'b0);

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_UP   = 2'b01;
    localparam logic [1:0] KIND_DOWN = 2'b10;
    localparam logic [1:0] KIND_BAD  = 2'b11;

    // One filter step: returns {level, run}. A sample matching the level
    // clears the run; the FILTER_LEN-th consecutive differing sample flips it.
    function automatic logic [RUN_W:0] filt_next(input logic             sample,
                                                 input logic             level,
                                                 input logic [RUN_W-1:0] run);
        logic [RUN_W:0] res;
        if (sample == level) begin
            res = {level, RUN_ZERO};
        end else if (run == RUN_LAST) begin
            res = {~level, RUN_ZERO};
        end else begin
            res = {level, run + RUN_ONE};
        end
        return res;
    endfunction

    // Classify a {A,B} state transition. Up order is 00->10->11->01->00.
    function automatic logic [1:0] classify(input logic [1:0] prev,
                                            input logic [1:0] cur);
        logic [1:0] kind;
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: kind = KIND_UP;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: kind = KIND_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: kind = KIND_BAD;
            default:                                kind = KIND_NONE;
        endcase
        return kind;
    endfunction

    logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
    logic                   a_f_q, a_f_d, b_f_q, b_f_d;
    logic [RUN_W-1:0]       a_run_q, a_run_d, b_run_q, b_run_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   warm_s;
    logic [1:0]             prev_q, prev_d;
    logic                   primed_q, primed_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   step_q, step_d;
    logic                   dir_q, dir_d;
    logic                   err_q, err_d;
    logic [1:0]             cur_s;
    logic [1:0]             kind_s;
    logic                   settled_s;
    logic                   a_smp_s, b_smp_s;

    assign a_smp_s = a_sync_q[SYNC_STAGES-1];
    assign b_smp_s = b_sync_q[SYNC_STAGES-1];

    // Input synchroniser shift chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q <= {SYNC_STAGES{1'b0}};
            b_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], quad_a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], quad_b};
        end
    end

    // Glitch filter next state for both channels.
    always_comb begin
        {a_f_d, a_run_d} = filt_next(a_smp_s, a_f_q, a_run_q);
        {b_f_d, b_run_d} = filt_next(b_smp_s, b_f_q, b_run_q);
    end

    // Glitch filter level and run registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_f_q   <= 1'b0;
            b_f_q   <= 1'b0;
            a_run_q <= RUN_ZERO;
            b_run_q <= RUN_ZERO;
        end else begin
            a_f_q   <= a_f_d;
            b_f_q   <= b_f_d;
            a_run_q <= a_run_d;
            b_run_q <= b_run_d;
        end
    end

    // Count edges since reset until the synchroniser holds real pin samples;
    // before that its output is only the reset value.
    always_comb begin
        if (fill_q == FILL_DONE) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FILL_ONE;
        end
    end

    assign warm_s = (fill_q == FILL_DONE);

    // Synchroniser fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= {FILL_W{1'b0}};
        end else begin
            fill_q <= fill_d;
        end
    end

    // Decode, priming and output next state.
    always_comb begin
        cur_s     = {a_f_q, b_f_q};
        kind_s    = classify(prev_q, cur_s);
        // Filtered levels agree with the pins: safe to take them as the start
        // state. Covers inputs that were not 00 when reset released.
        settled_s = warm_s && (a_smp_s == a_f_q) && (b_smp_s == b_f_q);

        prev_d   = prev_q;
        primed_d = primed_q;
        count_d  = count_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        err_d    = err_q;

        if (!primed_q) begin
            if (settled_s) begin
                prev_d   = cur_s;
                primed_d = 1'b1;
            end else begin
                prev_d   = prev_q;
            end
        end else begin
            prev_d = cur_s;
            case (kind_s)
                KIND_UP: begin
                    step_d  = 1'b1;
                    dir_d   = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
                KIND_DOWN: begin
                    step_d  = 1'b1;
                    dir_d   = 1'b0;
                    count_d = count_q - CNT_ONE;
                end
                KIND_BAD: begin
                    err_d = 1'b1;
                end
                default: begin
                    step_d = 1'b0;
                end
            endcase
        end

        // Clear wins over a coincident step for count/err; step/dir still pulse.
        if (clear) begin
            count_d = CNT_ZERO;
            err_d   = 1'b0;
        end else begin
            err_d   = err_d;
        end
    end

    // Decode state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            count_q  <= CNT_ZERO;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            count_q  <= count_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign count = count_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//
// Directed self-checking bench for quad_decoder with default parameters
// (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3). Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       quad_a;
    logic       quad_b;
    logic       clear;
    logic [3:0] count;
    logic       step;
    logic       dir;
    logic       err;

    int checks = 0;
    int errors = 0;

    quad_decoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .quad_a (quad_a),
        .quad_b (quad_b),
        .clear  (clear),
        .count  (count),
        .step   (step),
        .dir    (dir),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a new A/B level, wait (bounded) for the step pulse and hold the
    // level at least 8 cycles. lat = ticks until step seen, -1 if none.
    task automatic drive_and_wait(input logic a, input logic b, output int lat,
                                  output logic d, output logic [3:0] c);
        lat = -1;
        d   = 1'b0;
        c   = 4'd0;
        quad_a = a;
        quad_b = b;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (step === 1'b1 && lat < 0) begin
                lat = i;
                d   = dir;
                c   = count;
            end
            if (lat > 0 && i >= 8) break;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        quad_a = 1'b0;
        quad_b = 1'b0;
        clear  = 1'b0;
        tick(3);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b exp 0", dir); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_up_cycle();
        logic [1:0] lv [4];
        int lat; logic d; logic [3:0] c;
        lv = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 4; k++) begin
            drive_and_wait(lv[k][1], lv[k][0], lat, d, c);
            checks++; if (lat != 6) begin errors++; $display("FAIL up_latency[%0d] got %0d exp 6", k, lat); end
            checks++; if (d !== 1'b1) begin errors++; $display("FAIL up_dir[%0d] got %b exp 1", k, d); end
            checks++; if (c !== 4'(k + 1)) begin errors++; $display("FAIL up_count[%0d] got %0d exp %0d", k, c, k + 1); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL up_err got %b exp 0", err); end
    endtask

    task automatic test_down_wrap();
        logic [1:0] lv [4];
        logic [3:0] ex [4];
        int lat; logic d; logic [3:0] c;
        // Move to count=2 at state 00: up to 11 (count 6), clear, up 01, 00.
        drive_and_wait(1'b1, 1'b0, lat, d, c);
        drive_and_wait(1'b1, 1'b1, lat, d, c);
        checks++; if (c !== 4'd6) begin errors++; $display("FAIL pre_clear_count got %0d exp 6", c); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL idle_clear_count got %0d exp 0", count); end
        drive_and_wait(1'b0, 1'b1, lat, d, c);
        drive_and_wait(1'b0, 1'b0, lat, d, c);
        checks++; if (c !== 4'd2) begin errors++; $display("FAIL down_start_count got %0d exp 2", c); end
        lv = '{2'b01, 2'b11, 2'b10, 2'b00};
        ex = '{4'd1, 4'd0, 4'd15, 4'd14};
        for (int k = 0; k < 4; k++) begin
            drive_and_wait(lv[k][1], lv[k][0], lat, d, c);
            checks++; if (lat != 6) begin errors++; $display("FAIL down_latency[%0d] got %0d exp 6", k, lat); end
            checks++; if (d !== 1'b0) begin errors++; $display("FAIL down_dir[%0d] got %b exp 0", k, d); end
            checks++; if (c !== ex[k]) begin errors++; $display("FAIL down_count[%0d] got %0d exp %0d", k, c, ex[k]); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", err); end
    endtask

    task automatic test_glitch_filter();
        int nsteps;
        logic d1, d2;
        logic [3:0] c1, c2;
        // 2-cycle pulse: filtered away.
        quad_a = 1'b1;
        tick(2);
        quad_a = 1'b0;
        nsteps = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (step === 1'b1) nsteps++;
        end
        checks++; if (nsteps != 0) begin errors++; $display("FAIL glitch2_steps got %0d exp 0", nsteps); end
        checks++; if (count !== 4'd14) begin errors++; $display("FAIL glitch2_count got %0d exp 14", count); end
        // 4-cycle pulse: passes; one up step then one down step on release.
        nsteps = 0; d1 = 1'b0; d2 = 1'b1; c1 = 4'd0; c2 = 4'd0;
        quad_a = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) quad_a = 1'b0;
            tick(1);
            if (step === 1'b1) begin
                nsteps++;
                if (nsteps == 1) begin d1 = dir; c1 = count; end
                if (nsteps == 2) begin d2 = dir; c2 = count; end
            end
        end
        checks++; if (nsteps != 2) begin errors++; $display("FAIL pulse4_steps got %0d exp 2", nsteps); end
        checks++; if (d1 !== 1'b1 || c1 !== 4'd15) begin errors++; $display("FAIL pulse4_up got dir %b count %0d exp dir 1 count 15", d1, c1); end
        checks++; if (d2 !== 1'b0 || c2 !== 4'd14) begin errors++; $display("FAIL pulse4_down got dir %b count %0d exp dir 0 count 14", d2, c2); end
    endtask

    task automatic test_illegal();
        int nsteps;
        int lat; logic d; logic [3:0] c;
        quad_a = 1'b1;
        quad_b = 1'b1;
        nsteps = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (step === 1'b1) nsteps++;
        end
        checks++; if (nsteps != 0) begin errors++; $display("FAIL illegal_steps got %0d exp 0", nsteps); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", err); end
        checks++; if (count !== 4'd14) begin errors++; $display("FAIL illegal_count got %0d exp 14", count); end
        drive_and_wait(1'b0, 1'b1, lat, d, c);
        checks++; if (lat != 6 || d !== 1'b1 || c !== 4'd15) begin errors++; $display("FAIL after_err_step got lat %0d dir %b count %0d exp lat 6 dir 1 count 15", lat, d, c); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (err !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL clear_err got err %b count %0d exp err 0 count 0", err, count); end
        drive_and_wait(1'b0, 1'b0, lat, d, c);
        checks++; if (c !== 4'd1) begin errors++; $display("FAIL post_clear_step got %0d exp 1", c); end
    endtask

    task automatic test_prime_nonzero();
        int nsteps;
        int lat; logic d; logic [3:0] c;
        rst_n  = 1'b0;
        quad_a = 1'b1;
        quad_b = 1'b1;
        tick(2);
        checks++; if (count !== 4'd0 || step !== 1'b0) begin errors++; $display("FAIL midseq_reset got count %0d step %b exp 0 0", count, step); end
        rst_n = 1'b1;
        nsteps = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (step === 1'b1) nsteps++;
        end
        checks++; if (nsteps != 0) begin errors++; $display("FAIL prime_steps got %0d exp 0", nsteps); end
        checks++; if (err !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL prime_state got err %b count %0d exp 0 0", err, count); end
        drive_and_wait(1'b0, 1'b1, lat, d, c);
        checks++; if (lat != 6 || d !== 1'b1 || c !== 4'd1) begin errors++; $display("FAIL prime_first_step got lat %0d dir %b count %0d exp 6 1 1", lat, d, c); end
    endtask

    task automatic test_clear_with_step();
        // State 01, count 1. 01->00 is an up edge; clear lands on its edge.
        quad_a = 1'b0;
        quad_b = 1'b0;
        tick(5);
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL early_step got %b exp 0", step); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checks++; if (step !== 1'b1 || dir !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL clear_step got step %b dir %b count %0d exp 1 1 0", step, dir, count); end
        tick(4);
        quad_a = 1'b1;
        tick(6);
        checks++; if (step !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL pre_async step %b count %0d exp 1 1", step, count); end
        rst_n = 1'b0;
        #2;
        checks++; if (count !== 4'd0 || step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL async_reset got count %0d step %b dir %b err %b exp all 0", count, step, dir, err); end
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_up_cycle();
        test_down_wrap();
        test_glitch_filter();
        test_illegal();
        test_prime_nonzero();
        test_clear_with_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
